lsu_bus_if: RTL and testbench
=============================

Name: lsu_bus_if

Overview:
- Parametrised MEM-stage load/store unit; replaces the fixed single-cycle word memory path.
- Sits between MEM-stage pipeline controls and a valid/ready data bus.
- Supports byte, half, word (and dword when DATA_W=64) accesses with sign/zero extension.
- Generates mem_stall to freeze IDEX/EXMEM/MEMWB while a bus access is outstanding.

Parameters:
- DATA_W, 32, bus/data width; legal values 32 or 64.
- ADDR_W, 32, byte-address width.
- TIMEOUT_CYC, 256, cycles before a stuck access is abandoned (used only with LSU_TIMEOUT_EN).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  MEM stage holds a load or store.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  mem_size_t: BYTE=0, HALF=1, WORD=2, DWORD=3 (DWORD legal only when DATA_W=64).
- req_signed  in  1  load sign-extends when 1.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-aligned.
- rdata  out  DATA_W  extended load result, registered.
- mem_stall  out  1  freeze upstream pipeline registers.
- misalign  out  1  one-cycle pulse on a misaligned request.
- timeout  out  1  one-cycle pulse on an abandoned access.
- bus_req_valid  out  1  bus request.
- bus_req_ready  in  1  bus accepts the request.
- bus_we  out  1  bus write.
- bus_addr  out  ADDR_W  request address with the low log2(DATA_W/8) bits forced to 0.
- bus_be  out  DATA_W/8  byte enables.
- bus_wdata  out  DATA_W  lane-replicated store data.
- bus_rsp_valid  in  1  read data valid or write acknowledge.
- bus_rdata  in  DATA_W  read data.

Behaviour:
- Reset (rst=0, async): state=IDLE; rdata, misalign, timeout, bus_req_valid, bus_we, bus_addr, bus_be, bus_wdata all 0.
- FSM states: IDLE, REQ, RSP, DONE (lsu_state_t).
- IDLE:
  - req_valid=1 with an aligned request: capture we/size/signed/addr/wdata, go to REQ.
  - mem_stall = req_valid combinationally in IDLE.
- REQ:
  - bus_req_valid=1 and bus fields driven from the captured values.
  - On bus_req_ready=1, go to RSP.
  - mem_stall=1.
- RSP:
  - Wait for bus_rsp_valid. bus_rsp_valid is sampled only in RSP and ignored in every other state.
  - On bus_rsp_valid=1: for a load, register the extracted/extended lane into rdata; then go to DONE. Stores leave rdata unchanged.
  - mem_stall=1.
- DONE:
  - mem_stall=0 for exactly one cycle; the pipeline advances; next state is IDLE.
- Latency:
  - With ready=1 in REQ and rsp_valid on the first RSP cycle, mem_stall is high for 3 cycles and the instruction leaves MEM at the end of the DONE cycle.
  - Back-to-back accesses each pay the full sequence.
- Alignment:
  - HALF requires addr[0]=0; WORD requires addr[1:0]=0; DWORD requires addr[2:0]=0.
  - On a misaligned request in IDLE: no bus access, misalign=1 for one cycle, mem_stall=0, rdata<=0, store suppressed, state stays IDLE.
- Lanes (little-endian):
  - Lane offset = addr[log2(DATA_W/8)-1:0].
  - BYTE be = 1<<off; HALF be = 2'b11<<off; WORD be = 4'hF<<off; DWORD be = all ones.
  - bus_wdata replicates the low 8/16/32 bits of req_wdata across all lanes.
- Load extraction: shift bus_rdata right by 8*off, take the size, then sign-extend (req_signed=1) or zero-extend to DATA_W.
- req_* inputs may change after capture; the captured copy is authoritative.
- Reset mid-access: the FSM returns to IDLE immediately and the outstanding bus transaction is abandoned. The bus shares the same reset.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined: a counter clears on entry to REQ and increments each cycle in REQ/RSP.
  - On reaching TIMEOUT_CYC-1 without completing: go to DONE with rdata<=0 and timeout=1 for that DONE cycle; bus_req_valid drops.
- Undefined: no counter; the FSM waits indefinitely; the timeout port is tied to 0.

Decomposition:
- mips_pkg gains:
  - mem_size_t enum (BYTE/HALF/WORD/DWORD).
  - lsu_state_t enum (IDLE/REQ/RSP/DONE).
  - Function/constant for lane-offset width, log2(DATA_W/8).
- Sub-module lsu_lane_align (combinational, parametrised on DATA_W):
  - Produces be and replicated wdata from size/offset.
  - Extracts and extends load data from bus_rdata.

Test Plan:
- Aligned LW at 0x100, bus_rdata=0xDEADBEEF, ready and rsp immediate -> mem_stall high for 3 cycles; rdata=0xDEADBEEF in DONE; bus_be=4'hF; bus_addr=0x100.
- LB signed at 0x103, bus_rdata=0x80FF_1234 -> bus_be=4'b1000, rdata=0xFFFFFF80; LBU same address -> rdata=0x00000080.
- SH at 0x202 with wdata=0x0000ABCD -> bus_we=1, bus_be=4'b1100, bus_wdata=0xABCDABCD, bus_addr=0x200; stall held until write ack.
- LW at 0x101 -> misalign pulse; no bus_req_valid; mem_stall=0; rdata=0.
- bus_req_ready held low for 10 cycles, then rsp 5 cycles later -> mem_stall stays high throughout; rst asserted mid-RSP -> all outputs 0 and state IDLE on the next edge.
- LSU_TIMEOUT_EN with TIMEOUT_CYC=8 and no rsp -> timeout pulse; rdata=0; mem_stall released after 8 cycles in REQ/RSP.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types for the MEM-stage load/store path: access sizes, LSU FSM
// states and the lane-offset width helper.
package mips_pkg;

   typedef enum logic [1:0] {
      BYTE  = 2'd0,
      HALF  = 2'd1,
      WORD  = 2'd2,
      DWORD = 2'd3
   } mem_size_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RSP  = 2'd2,
      DONE = 2'd3
   } lsu_state_t;

   // Number of address bits that select a byte lane within one bus word.
   function automatic int lane_off_w(input int data_w);
      return $clog2(data_w / 8);
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering for the LSU: byte enables and replicated
// store data from size/offset, and extraction/extension of load data.
module lsu_lane_align
   import mips_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  mem_size_t                      size,
   input  logic [lane_off_w(DATA_W)-1:0]  off,
   input  logic                           sign,
   input  logic [DATA_W-1:0]              wdata_in,
   input  logic [DATA_W-1:0]              rdata_in,
   output logic [DATA_W/8-1:0]            be,
   output logic [DATA_W-1:0]              wdata_out,
   output logic [DATA_W-1:0]              rdata_out
);

   localparam int NB = DATA_W / 8;

   // Byte enables: the access size as a contiguous mask shifted to the lane.
   always_comb begin
      case (size)
         BYTE:    be = NB'(1) << off;
         HALF:    be = NB'(3) << off;
         WORD:    be = NB'(15) << off;
         default: be = '1;
      endcase
   end

   // Each byte lane takes the store byte it would hold if the right-aligned
   // value were repeated across the whole bus word.
   genvar gi;
   generate
      for (gi = 0; gi < NB; gi++) begin : g_lane
         assign wdata_out[8*gi +: 8] =
            (size == BYTE) ? wdata_in[7:0] :
            (size == HALF) ? wdata_in[8*(gi % 2) +: 8] :
            (size == WORD) ? wdata_in[8*(gi % 4) +: 8] :
                             wdata_in[8*gi +: 8];
      end
   endgenerate

   // Load path: move the addressed lane to bit 0, then fill everything above
   // the access size with the sign bit or zeros.
   always_comb begin
      logic [DATA_W-1:0] shifted;
      int                msb;
      shifted = rdata_in >> {off, 3'b000};
      msb     = DATA_W - 1;
      case (size)
         BYTE:    msb = 7;
         HALF:    msb = 15;
         WORD:    msb = 31;
         default: msb = DATA_W - 1;
      endcase
      for (int i = 0; i < DATA_W; i++) begin
         rdata_out[i] = (i <= msb) ? shifted[i] : (sign & shifted[msb]);
      end
   end

endmodule

// File: rtl/lsu_bus_if.sv
// MEM-stage load/store unit bridging pipeline controls to a valid/ready bus.
// Optional macro LSU_TIMEOUT_EN adds an access watchdog (TIMEOUT_CYC cycles).
module lsu_bus_if
   import mips_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 32,
   parameter int TIMEOUT_CYC = 256
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   input  logic                 req_we,
   input  mem_size_t            req_size,
   input  logic                 req_signed,
   input  logic [ADDR_W-1:0]    req_addr,
   input  logic [DATA_W-1:0]    req_wdata,
   output logic [DATA_W-1:0]    rdata,
   output logic                 mem_stall,
   output logic                 misalign,
   output logic                 timeout,
   output logic                 bus_req_valid,
   input  logic                 bus_req_ready,
   output logic                 bus_we,
   output logic [ADDR_W-1:0]    bus_addr,
   output logic [DATA_W/8-1:0]  bus_be,
   output logic [DATA_W-1:0]    bus_wdata,
   input  logic                 bus_rsp_valid,
   input  logic [DATA_W-1:0]    bus_rdata
);

   localparam int OW = lane_off_w(DATA_W);

   lsu_state_t          state_reg, state_next;
   logic                cap_we_reg, cap_signed_reg;
   mem_size_t           cap_size_reg;
   logic [OW-1:0]       cap_off_reg;
   logic [DATA_W-1:0]   rdata_reg;
   logic                misalign_reg;
   logic                bus_req_valid_reg, bus_we_reg;
   logic [ADDR_W-1:0]   bus_addr_reg;
   logic [DATA_W/8-1:0] bus_be_reg;
   logic [DATA_W-1:0]   bus_wdata_reg;

   logic                aligned, capture, misalign_set, rsp_load;
   logic                timeout_fire, to_hit;
   mem_size_t           sel_size;
   logic [OW-1:0]       sel_off;
   logic [DATA_W/8-1:0] lane_be;
   logic [DATA_W-1:0]   lane_wdata, lane_rdata;

   assign rdata         = rdata_reg;
   assign misalign      = misalign_reg;
   assign bus_req_valid = bus_req_valid_reg;
   assign bus_we        = bus_we_reg;
   assign bus_addr      = bus_addr_reg;
   assign bus_be        = bus_be_reg;
   assign bus_wdata     = bus_wdata_reg;

   // Alignment of the incoming request; DWORD is only legal on a 64-bit bus.
   always_comb begin
      aligned = 1'b1;
      case (req_size)
         HALF:    aligned = ~req_addr[0];
         WORD:    aligned = (req_addr[1:0] == 2'b00);
         DWORD:   aligned = (DATA_W == 64) && (req_addr[2:0] == 3'b000);
         default: aligned = 1'b1;
      endcase
   end

   // The aligner sees the live request while idle (store lanes are captured
   // then) and the captured copy afterwards (load extraction in RSP).
   assign sel_size = (state_reg == IDLE) ? req_size : cap_size_reg;
   assign sel_off  = (state_reg == IDLE) ? req_addr[OW-1:0] : cap_off_reg;

   lsu_lane_align #(.DATA_W(DATA_W)) u_align (
      .size      (sel_size),
      .off       (sel_off),
      .sign      (cap_signed_reg),
      .wdata_in  (req_wdata),
      .rdata_in  (bus_rdata),
      .be        (lane_be),
      .wdata_out (lane_wdata),
      .rdata_out (lane_rdata)
   );

`ifdef LSU_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0] cnt_reg;
   logic             timeout_reg;

   assign to_hit  = (cnt_reg == CNT_W'(TIMEOUT_CYC - 1));
   assign timeout = timeout_reg;

   // Watchdog: restarts on each new access, counts every REQ/RSP cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_reg     <= '0;
         timeout_reg <= 1'b0;
      end else begin
         timeout_reg <= timeout_fire;
         if (capture) begin
            cnt_reg <= '0;
         end else if (state_reg == REQ || state_reg == RSP) begin
            cnt_reg <= cnt_reg + 1'b1;
         end
      end
   end
`else
   logic [31:0] unused_timeout_cyc;
   assign unused_timeout_cyc = 32'(TIMEOUT_CYC);
   assign to_hit  = 1'b0;
   assign timeout = 1'b0;
`endif

   // Next-state and stall logic; a completing handshake beats the watchdog.
   always_comb begin
      state_next   = state_reg;
      mem_stall    = 1'b0;
      capture      = 1'b0;
      misalign_set = 1'b0;
      rsp_load     = 1'b0;
      timeout_fire = 1'b0;
      case (state_reg)
         IDLE: begin
            if (req_valid) begin
               if (aligned) begin
                  capture    = 1'b1;
                  mem_stall  = 1'b1;
                  state_next = REQ;
               end else begin
                  misalign_set = 1'b1;
               end
            end
         end
         REQ: begin
            mem_stall = 1'b1;
            if (bus_req_ready) begin
               state_next = RSP;
            end else if (to_hit) begin
               timeout_fire = 1'b1;
               state_next   = DONE;
            end
         end
         RSP: begin
            mem_stall = 1'b1;
            if (bus_rsp_valid) begin
               rsp_load   = ~cap_we_reg;
               state_next = DONE;
            end else if (to_hit) begin
               timeout_fire = 1'b1;
               state_next   = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State register plus captured request attributes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg      <= IDLE;
         cap_we_reg     <= 1'b0;
         cap_signed_reg <= 1'b0;
         cap_size_reg   <= BYTE;
         cap_off_reg    <= '0;
      end else begin
         state_reg <= state_next;
         if (capture) begin
            cap_we_reg     <= req_we;
            cap_signed_reg <= req_signed;
            cap_size_reg   <= req_size;
            cap_off_reg    <= req_addr[OW-1:0];
         end
      end
   end

   // Bus request fields are loaded at capture and held until the next access.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus_req_valid_reg <= 1'b0;
         bus_we_reg        <= 1'b0;
         bus_addr_reg      <= '0;
         bus_be_reg        <= '0;
         bus_wdata_reg     <= '0;
      end else if (capture) begin
         bus_req_valid_reg <= 1'b1;
         bus_we_reg        <= req_we;
         bus_addr_reg      <= {req_addr[ADDR_W-1:OW], {OW{1'b0}}};
         bus_be_reg        <= lane_be;
         bus_wdata_reg     <= lane_wdata;
      end else if (state_reg == REQ && state_next != REQ) begin
         bus_req_valid_reg <= 1'b0;
      end
   end

   // Load result and one-cycle error pulses; errors clear the load result.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdata_reg    <= '0;
         misalign_reg <= 1'b0;
      end else begin
         misalign_reg <= misalign_set;
         if (misalign_set || timeout_fire) begin
            rdata_reg <= '0;
         end else if (rsp_load) begin
            rdata_reg <= lane_rdata;
         end
      end
   end

endmodule

// File: tb/tb_lsu_bus_if.sv
// Scoreboard bench for lsu_bus_if (32-bit bus, TIMEOUT_CYC=8).
module tb_lsu_bus_if;
   import mips_pkg::*;

   localparam int TO_CYC = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_we, req_signed;
   mem_size_t   req_size;
   logic [31:0] req_addr, req_wdata;
   logic [31:0] rdata;
   logic        mem_stall, misalign, timeout;
   logic        bus_req_valid, bus_req_ready, bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_rsp_valid;
   logic [31:0] bus_rdata;

   typedef struct {
      logic [31:0] rdata;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] model_rdata = 32'h0;
   int          n_checks = 0;
   int          n_pass   = 0;

   always #5 clk = ~clk;

   lsu_bus_if #(.DATA_W(32), .ADDR_W(32), .TIMEOUT_CYC(TO_CYC)) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_we        (req_we),
      .req_size      (req_size),
      .req_signed    (req_signed),
      .req_addr      (req_addr),
      .req_wdata     (req_wdata),
      .rdata         (rdata),
      .mem_stall     (mem_stall),
      .misalign      (misalign),
      .timeout       (timeout),
      .bus_req_valid (bus_req_valid),
      .bus_req_ready (bus_req_ready),
      .bus_we        (bus_we),
      .bus_addr      (bus_addr),
      .bus_be        (bus_be),
      .bus_wdata     (bus_wdata),
      .bus_rsp_valid (bus_rsp_valid),
      .bus_rdata     (bus_rdata)
   );

   // ---------------- reference model ----------------
   function automatic logic [3:0] m_be(input mem_size_t s, input logic [31:0] a);
      int n;
      int off;
      logic [3:0] b;
      n   = (s == BYTE) ? 1 : (s == HALF) ? 2 : 4;
      off = int'(a[1:0]);
      b   = 4'b0000;
      for (int i = 0; i < 4; i++) if (i >= off && i < off + n) b[i] = 1'b1;
      return b;
   endfunction

   function automatic logic [31:0] m_wdata(input mem_size_t s, input logic [31:0] w);
      case (s)
         BYTE:    return {4{w[7:0]}};
         HALF:    return {2{w[15:0]}};
         default: return w;
      endcase
   endfunction

   function automatic logic [31:0] m_load(input mem_size_t s, input logic sg,
                                          input logic [31:0] a, input logic [31:0] rd);
      int          off;
      logic [7:0]  b8;
      logic [15:0] h16;
      off = int'(a[1:0]);
      case (s)
         BYTE: begin
            b8 = rd[8*off +: 8];
            return sg ? {{24{b8[7]}}, b8} : {24'h0, b8};
         end
         HALF: begin
            h16 = rd[8*off +: 16];
            return sg ? {{16{h16[15]}}, h16} : {16'h0, h16};
         end
         default: return rd;
      endcase
   endfunction

   // ---------------- one complete access ----------------
   task automatic run_access(input string name, input logic we, input mem_size_t size,
                             input logic sgn, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] rsp_data,
                             input int ready_delay, input int rsp_delay,
                             input logic exp_to);
      exp_t e, got;
      int   stall, rw, sw, exp_stall;
      logic seen, accepted, responded, done;
      e.we    = we;
      e.be    = m_be(size, addr);
      e.addr  = {addr[31:2], 2'b00};
      e.wdata = m_wdata(size, wdata);
      e.rdata = exp_to ? 32'h0 : (we ? model_rdata : m_load(size, sgn, addr, rsp_data));
      model_rdata = e.rdata;
      exp_q.push_back(e);
      exp_stall = exp_to ? 1 + TO_CYC : 3 + ready_delay + rsp_delay;

      stall = 0; rw = 0; sw = 0;
      seen = 1'b0; accepted = 1'b0; responded = 1'b0; done = 1'b0;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
      req_addr = addr; req_wdata = wdata;
      bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;
      for (int cyc = 0; cyc < 100; cyc++) begin
         if (cyc == 1) begin
            // Scramble the live request; only the captured copy may matter.
            req_we = ~we; req_signed = ~sgn; req_size = (size == BYTE) ? WORD : BYTE;
            req_addr = ~addr; req_wdata = ~wdata;
         end
         #1;
         if (cyc == 0) begin
            n_checks++;
            if (mem_stall !== 1'b1) $display("FAIL %s idle_stall: got %b want 1", name, mem_stall);
            else n_pass++;
         end
         if (mem_stall === 1'b1) begin
            stall++;
         end else if (cyc > 0) begin
            done = 1'b1;
            req_valid = 1'b0; bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;
            got = exp_q.pop_front();
            n_checks++;
            if (rdata !== got.rdata) $display("FAIL %s rdata: got %h want %h", name, rdata, got.rdata);
            else n_pass++;
            n_checks++;
            if (stall != exp_stall) $display("FAIL %s stall_cycles: got %0d want %0d", name, stall, exp_stall);
            else n_pass++;
            n_checks++;
            if (timeout !== exp_to) $display("FAIL %s timeout: got %b want %b", name, timeout, exp_to);
            else n_pass++;
            $display("%s: addr=%h be=%b we=%b rdata=%h stall=%0d timeout=%b",
                     name, addr, got.be, we, rdata, stall, timeout);
            break;
         end
         bus_req_ready = 1'b0;
         bus_rsp_valid = 1'b0;
         bus_rdata     = $urandom;
         if (bus_req_valid === 1'b1) begin
            if (!seen) begin
               seen = 1'b1;
               n_checks++;
               if (bus_we !== e.we) $display("FAIL %s bus_we: got %b want %b", name, bus_we, e.we);
               else n_pass++;
               n_checks++;
               if (bus_be !== e.be) $display("FAIL %s bus_be: got %b want %b", name, bus_be, e.be);
               else n_pass++;
               n_checks++;
               if (bus_addr !== e.addr) $display("FAIL %s bus_addr: got %h want %h", name, bus_addr, e.addr);
               else n_pass++;
               if (we) begin
                  n_checks++;
                  if (bus_wdata !== e.wdata) $display("FAIL %s bus_wdata: got %h want %h", name, bus_wdata, e.wdata);
                  else n_pass++;
               end
            end
            if (rw == ready_delay) begin
               bus_req_ready = 1'b1;
               accepted = 1'b1;
            end else begin
               bus_rsp_valid = 1'b1;   // must be ignored outside RSP
            end
            rw++;
         end else if (accepted && !responded && rsp_delay >= 0) begin
            if (sw == rsp_delay) begin
               bus_rsp_valid = 1'b1;
               bus_rdata     = rsp_data;
               responded     = 1'b1;
            end
            sw++;
         end
         @(negedge clk);
      end
      if (!done) begin
         n_checks++;
         $display("FAIL %s completion: got no DONE cycle want DONE within 100 cycles", name);
         req_valid = 1'b0; bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;
         void'(exp_q.pop_front());
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b0;
      req_valid = 1'b0; req_we = 1'b0; req_size = BYTE; req_signed = 1'b0;
      req_addr = 32'h0; req_wdata = 32'h0;
      bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rdata = 32'h0;
      #1;
      n_checks++;
      if ({rdata, bus_addr, bus_wdata} !== 96'h0) $display("FAIL reset data: got %h/%h/%h want 0", rdata, bus_addr, bus_wdata);
      else n_pass++;
      n_checks++;
      if ({misalign, timeout, bus_req_valid, bus_we, bus_be, mem_stall} !== 9'h0)
         $display("FAIL reset ctrl: got %b want 0", {misalign, timeout, bus_req_valid, bus_we, bus_be, mem_stall});
      else n_pass++;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      $display("reset: outputs checked");
   endtask

   task automatic test_loads();
      run_access("lw_0x100", 1'b0, WORD, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 1'b0);
      run_access("lb_0x103", 1'b0, BYTE, 1'b1, 32'h103, 32'h0, 32'h80FF1234, 0, 0, 1'b0);
      run_access("lbu_0x103", 1'b0, BYTE, 1'b0, 32'h103, 32'h0, 32'h80FF1234, 0, 0, 1'b0);
   endtask

   task automatic test_store();
      run_access("sh_0x202", 1'b1, HALF, 1'b0, 32'h202, 32'h0000ABCD, 32'h0, 0, 2, 1'b0);
   endtask

   task automatic test_misalign();
      exp_t e;
      e.rdata = 32'h0; e.we = 1'b0; e.be = 4'h0; e.addr = 32'h0; e.wdata = 32'h0;
      model_rdata = 32'h0;
      exp_q.push_back(e);
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_size = WORD; req_signed = 1'b0; req_addr = 32'h101;
      #1;
      n_checks++;
      if (mem_stall !== 1'b0) $display("FAIL misalign stall: got %b want 0", mem_stall);
      else n_pass++;
      @(negedge clk);
      req_valid = 1'b0;
      e = exp_q.pop_front();
      n_checks++;
      if (misalign !== 1'b1) $display("FAIL misalign pulse: got %b want 1", misalign);
      else n_pass++;
      n_checks++;
      if (rdata !== e.rdata) $display("FAIL misalign rdata: got %h want %h", rdata, e.rdata);
      else n_pass++;
      n_checks++;
      if (bus_req_valid !== 1'b0) $display("FAIL misalign bus_req_valid: got %b want 0", bus_req_valid);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (misalign !== 1'b0 || bus_req_valid !== 1'b0)
         $display("FAIL misalign after: got misalign=%b bus_req_valid=%b want 0/0", misalign, bus_req_valid);
      else n_pass++;
      $display("lw_0x101: misaligned, rdata=%h", rdata);
   endtask

   task automatic test_slow_bus();
      run_access("lw_slow", 1'b0, WORD, 1'b0, 32'h10C, 32'h0, 32'h12345678, 10, 5, 1'b0);
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_size = WORD; req_signed = 1'b0; req_addr = 32'h300;
      @(negedge clk);
      bus_req_ready = 1'b1;
      @(negedge clk);
      bus_req_ready = 1'b0;
      @(negedge clk);
      n_checks++;
      if (mem_stall !== 1'b1 || bus_addr !== 32'h300)
         $display("FAIL midrst pre: got stall=%b addr=%h want 1/00000300", mem_stall, bus_addr);
      else n_pass++;
      rst = 1'b0;
      req_valid = 1'b0;
      #1;
      n_checks++;
      if ({rdata, bus_addr, bus_wdata} !== 96'h0) $display("FAIL midrst data: got %h/%h/%h want 0", rdata, bus_addr, bus_wdata);
      else n_pass++;
      n_checks++;
      if ({bus_req_valid, bus_we, bus_be, mem_stall, misalign, timeout} !== 9'h0)
         $display("FAIL midrst ctrl: got %b want 0", {bus_req_valid, bus_we, bus_be, mem_stall, misalign, timeout});
      else n_pass++;
      model_rdata = 32'h0;
      @(negedge clk);
      rst = 1'b1;
      $display("reset mid-RSP: outputs cleared");
   endtask

   task automatic test_back_to_back();
      run_access("sw_0x104", 1'b1, WORD, 1'b0, 32'h104, 32'hCAFEF00D, 32'h0, 0, 0, 1'b0);
      run_access("lh_0x102", 1'b0, HALF, 1'b1, 32'h102, 32'h0, 32'h80011234, 0, 0, 1'b0);
      run_access("lhu_0x100", 1'b0, HALF, 1'b0, 32'h100, 32'h0, 32'h5678F00D, 1, 0, 1'b0);
      run_access("sb_0x101", 1'b1, BYTE, 1'b0, 32'h101, 32'h000000A5, 32'h0, 0, 1, 1'b0);
      run_access("lb_0x101", 1'b0, BYTE, 1'b1, 32'h101, 32'h0, 32'h00007F00, 0, 0, 1'b0);
   endtask

`ifdef LSU_TIMEOUT_EN
   task automatic test_timeout();
      run_access("lw_timeout", 1'b0, WORD, 1'b0, 32'h400, 32'h0, 32'h0, 0, -1, 1'b1);
   endtask
`endif

   initial begin
      test_reset();
      test_loads();
      test_store();
      test_misalign();
      test_slow_bus();
      test_reset_mid();
      test_back_to_back();
`ifdef LSU_TIMEOUT_EN
      test_timeout();
`endif
      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
